rle_enc: RTL and testbench



---
 rtl/rle_pkg.sv | 23 ++
 rtl/str_reg.sv | 49 ++++
 rtl/rle_enc.sv | 173 +++++++++++++++++
 tb/tb_rle_enc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types for the run-length encoder: FSM states, the output word
// layout and the saturating repeat-count limit.
package rle_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      RUN
   } state_e;

   localparam int unsigned DW_MAX = 32;

   typedef struct packed {
      logic              rle;
      logic [DW_MAX-1:0] data;
   } word_t;

   // Largest count a CW-bit counter can hold; a run reaching it is emitted at once.
   function automatic logic [DW_MAX-1:0] cmax(input int unsigned cw);
      return DW_MAX'((64'd1 << cw) - 64'd1);
   endfunction

endpackage

// File: rtl/str_reg.sv
// Single-entry valid/ready register stage. It accepts a new word whenever it
// is empty or its current word is consumed in the same cycle.
module str_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // NOTE: every variable gets a default before the branches, so no latch is inferred.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clr) begin
         valid_d = 1'b0;
      end else if (in_valid && in_ready) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: registers update with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/rle_enc.sv
// Run-length encoder: collapses repeated samples into a sample word followed
// by a repeat-count word; a registered pass-through when disabled.
module rle_enc
   import rle_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ctl_ena,
   input  logic          ctl_clr,
   input  logic          ctl_flush,
   input  logic [DW-1:0] sti_data,
   input  logic          sti_valid,
   output logic          sti_ready,
   output logic [DW-1:0] sto_data,
   output logic          sto_rle,
   output logic          sto_valid,
   input  logic          sto_ready
);

   localparam logic [CW-1:0] CMAX = CW'(cmax(CW));

   state_e               state_q, state_d;
   logic [CW-1:0]        count_q, count_d, count_inc;
   logic [DW-1:0]        last_q, last_d;
   logic [DW-1:0]        pend_q, pend_d;
   logic                 pend_valid_q, pend_valid_d;
   logic                 flush_pend_q, flush_pend_d;

   logic                 flush_busy;
   logic                 accept;
   logic                 out_free;
   logic                 push_valid;
   word_t                push_word;
   word_t                out_word;
   logic [$bits(word_t)-1:0] out_bits;

   function automatic word_t sample_word(input logic [DW-1:0] x);
      word_t w;
      w.rle  = 1'b0;
      w.data = DW_MAX'(x);
      return w;
   endfunction

   function automatic word_t count_word(input logic [CW-1:0] c);
      word_t w;
      w.rle  = 1'b1;
      w.data = DW_MAX'(c);
      return w;
   endfunction

   // An enable drop outside IDLE behaves like a flush before bypass resumes.
   assign flush_busy = flush_pend_q || (!ctl_ena && (state_q != IDLE));
   assign sti_ready  = out_free && !pend_valid_q && !flush_busy && !rst;
   assign accept     = sti_valid && sti_ready;
   assign count_inc  = count_q + CW'(1);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      last_d       = last_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      flush_pend_d = flush_pend_q;
      push_valid   = 1'b0;
      push_word    = '0;

      if (ctl_clr) begin
         state_d      = IDLE;
         count_d      = '0;
         pend_valid_d = 1'b0;
         flush_pend_d = 1'b0;
      end else if (pend_valid_q) begin
         // A flush arriving now is deferred until the held sample is out.
         flush_pend_d = flush_pend_q || ctl_flush;
         if (out_free) begin
            push_valid   = 1'b1;
            push_word    = sample_word(pend_q);
            last_d       = pend_q;
            pend_valid_d = 1'b0;
            state_d      = DATA;
         end
      end else if (flush_busy) begin
         if (state_q == RUN) begin
            if (out_free) begin
               push_valid   = 1'b1;
               push_word    = count_word(count_q);
               count_d      = '0;
               state_d      = IDLE;
               flush_pend_d = 1'b0;
            end
         end else begin
            state_d      = IDLE;
            flush_pend_d = 1'b0;
         end
      end else begin
         flush_pend_d = ctl_flush;
         if (accept) begin
            if (!ctl_ena) begin
               push_valid = 1'b1;
               push_word  = sample_word(sti_data);
               state_d    = IDLE;
            end else if (state_q == IDLE) begin
               push_valid = 1'b1;
               push_word  = sample_word(sti_data);
               last_d     = sti_data;
               state_d    = DATA;
            end else if (sti_data == last_q) begin
               if (count_inc == CMAX) begin
                  push_valid = 1'b1;
                  push_word  = count_word(CMAX);
                  count_d    = '0;
                  state_d    = DATA;
               end else begin
                  count_d = count_inc;
                  state_d = RUN;
               end
            end else if (state_q == DATA) begin
               push_valid = 1'b1;
               push_word  = sample_word(sti_data);
               last_d     = sti_data;
            end else begin
               // Run ends: the count goes out now, the new sample on the next free cycle.
               push_valid   = 1'b1;
               push_word    = count_word(count_q);
               pend_d       = sti_data;
               pend_valid_d = 1'b1;
               count_d      = '0;
               state_d      = DATA;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         last_q       <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         last_q       <= last_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   str_reg #(
      .W($bits(word_t))
   ) u_out (
      .clk      (clk),
      .rst      (rst),
      .clr      (ctl_clr),
      .in_valid (push_valid),
      .in_data  (push_word),
      .in_ready (out_free),
      .out_valid(sto_valid),
      .out_data (out_bits),
      .out_ready(sto_ready)
   );

   assign out_word = word_t'(out_bits);
   assign sto_data = out_word.data[DW-1:0];
   assign sto_rle  = out_word.rle;

endmodule

// File: tb/tb_rle_enc.sv
// Scoreboard bench for rle_enc with a 4-bit counter so saturation is reachable.
module tb_rle_enc;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          ctl_ena   = 1'b0;
   logic          ctl_clr   = 1'b0;
   logic          ctl_flush = 1'b0;
   logic [DW-1:0] sti_data  = '0;
   logic          sti_valid = 1'b0;
   logic          sti_ready;
   logic [DW-1:0] sto_data;
   logic          sto_rle;
   logic          sto_valid;
   logic          sto_ready = 1'b1;

   int checks   = 0;
   int failures = 0;
   int rdy_mode = 0;

   logic [DW:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic        prev_clr   = 1'b0;
   logic [DW:0] prev_word  = '0;

   rle_enc #(
      .DW(DW),
      .CW(CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ctl_ena  (ctl_ena),
      .ctl_clr  (ctl_clr),
      .ctl_flush(ctl_flush),
      .sti_data (sti_data),
      .sti_valid(sti_valid),
      .sti_ready(sti_ready),
      .sto_data (sto_data),
      .sto_rle  (sto_rle),
      .sto_valid(sto_valid),
      .sto_ready(sto_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW:0] smp(input logic [DW-1:0] x);
      return {1'b0, x};
   endfunction

   function automatic logic [DW:0] cnt(input int c);
      return {1'b1, DW'(c)};
   endfunction

   // Downstream ready: 0 = always ready, 1 = 30% random, 2 = held low.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       sto_ready = 1'b1;
         1:       sto_ready = ($urandom_range(0, 99) < 30);
         default: sto_ready = 1'b0;
      endcase
   end

   // Output monitor: compares transfers against the scoreboard and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !prev_clr) begin
            check("stall_valid", sto_valid, 1);
            check("stall_word", {sto_rle, sto_data}, prev_word);
         end
         if (sto_valid && sto_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", exp_q.size(), 1);
            end else begin
               check("out_word", {sto_rle, sto_data}, exp_q.pop_front());
               if (sto_rle) check("cnt_range", (sto_data >= 1) && (sto_data <= CMAX), 1);
            end
         end
         prev_stall = sto_valid && !sto_ready;
         prev_word  = {sto_rle, sto_data};
         prev_clr   = ctl_clr;
      end
   end

   task automatic send(input logic [DW-1:0] x, input logic fl);
      int n;
      n = 0;
      sti_data  = x;
      sti_valid = 1'b1;
      ctl_flush = fl;
      @(negedge clk);
      while (!sti_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!sti_ready) check("send_timeout", sti_ready, 1);
      @(posedge clk);
      #1;
      sti_valid = 1'b0;
      ctl_flush = 1'b0;
   endtask

   task automatic flush();
      ctl_flush = 1'b1;
      @(posedge clk);
      #1;
      ctl_flush = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || sto_valid) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({"drain_", tag}, exp_q.size(), 0);
      repeat (4) @(posedge clk);
      #1;
      check({"idle_", tag}, sto_valid, 0);
   endtask

   initial begin
      logic [DW-1:0] v, prev;
      logic [3:0]    nib;
      int            total, len;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", sto_valid, 0);
      check("rst_data", sto_data, 0);
      check("rst_rle", sto_rle, 0);
      check("rst_ready", sti_ready, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Bypass: every word passes through unchanged as a sample.
      ctl_ena = 1'b0;
      for (int i = 0; i < 16; i++) begin
         nib = 4'(i);
         exp_q.push_back(smp({8{nib}}));
         send({8{nib}}, 1'b0);
      end
      drain("bypass", 200);

      // Basic run with a trailing flush in DATA that emits nothing.
      ctl_ena = 1'b1;
      exp_q.push_back(smp(32'hAAAA_0001));
      exp_q.push_back(cnt(3));
      exp_q.push_back(smp(32'hBBBB_0002));
      repeat (4) send(32'hAAAA_0001, 1'b0);
      send(32'hBBBB_0002, 1'b0);
      flush();
      drain("basic", 200);

      // Saturation at CMAX = 15.
      exp_q.push_back(smp(5));
      exp_q.push_back(cnt(15));
      exp_q.push_back(cnt(1));
      exp_q.push_back(smp(6));
      repeat (17) send(5, 1'b0);
      send(6, 1'b0);
      flush();
      drain("sat", 200);

      // Flush coinciding with a run-ending accept, then IDLE re-emits the sample.
      exp_q.push_back(smp(32'h1234_0000));
      exp_q.push_back(cnt(1));
      exp_q.push_back(smp(32'h5678_0000));
      exp_q.push_back(smp(32'h5678_0000));
      repeat (2) send(32'h1234_0000, 1'b0);
      send(32'h5678_0000, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      send(32'h5678_0000, 1'b0);
      flush();
      drain("flush_acc", 200);

      // Random runs under 30% downstream ready.
      rdy_mode = 1;
      total    = 0;
      prev     = 32'hFFFF_FFFF;
      while (total < 64) begin
         v = $urandom;
         if (v == prev) v = v ^ 32'h1;
         len = $urandom_range(1, 5);
         if (total + len > 64) len = 64 - total;
         exp_q.push_back(smp(v));
         for (int k = 0; k < len; k++) send(v, 1'b0);
         if (len > 1) exp_q.push_back(cnt(len - 1));
         prev  = v;
         total += len;
      end
      flush();
      drain("bp", 3000);
      rdy_mode = 0;
      @(posedge clk);
      #2;

      // Clear mid-run discards the pending count.
      exp_q.push_back(smp(7));
      repeat (3) send(7, 1'b0);
      ctl_clr = 1'b1;
      @(posedge clk);
      #1;
      ctl_clr = 1'b0;
      exp_q.push_back(smp(9));
      send(9, 1'b0);
      flush();
      drain("clr", 200);

      // Asynchronous reset with a count stalled at the output and a sample pending.
      exp_q.push_back(smp(7));
      repeat (2) send(7, 1'b0);
      drain("pre_rst", 200);
      rdy_mode = 2;
      @(posedge clk);
      #2;
      send(7, 1'b0);
      send(8, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      check("pre_rst_valid", sto_valid, 1);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_async_valid", sto_valid, 0);
      check("rst_async_ready", sti_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      rdy_mode = 0;
      @(posedge clk);
      #2;
      exp_q.push_back(smp(9));
      send(9, 1'b0);
      flush();
      drain("post_rst", 200);

      // Enable drop mid-run flushes the count before bypass takes D.
      exp_q.push_back(smp(32'hCCCC_CCCC));
      exp_q.push_back(cnt(2));
      exp_q.push_back(smp(32'hDDDD_DDDD));
      repeat (3) send(32'hCCCC_CCCC, 1'b0);
      ctl_ena = 1'b0;
      send(32'hDDDD_DDDD, 1'b0);
      drain("ena_drop", 200);
      ctl_ena = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
